mopshub_test_sequencer: RTL and testbench
=========================================

# mopshub_test_sequencer

Parametrised, synthesizable sequencer that drives the MOPSHUB bus test flow: sign-on wait, oscillator trim, RX test, end-wait plus gap, TX test and custom-message test, walking every active CAN bus per phase. It sits between the hub's status outputs and the data generator's per-bus test engines. It is a generalisation of the fixed 16-bus, hand-sequenced bench flow: runtime bus count, selectable phase mask, per-bus timeout, error capture and abort.

## Interface
- N_BUSES, 16: maximum number of CAN buses.
- BUS_W, 5: width of the bus index (≥ clog2(N_BUSES)+1).
- TIMEOUT, 4096: maximum WAIT cycles per bus and phase before a fail is recorded.
- GAP_CYCLES, 120: idle cycles between end-wait and the next phase.
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle run request; accepted only in IDLE.
- abort  in  1  synchronous abort; return to IDLE.
- mode_mask  in  4  enabled phases: bit0 trim, bit1 rx, bit2 tx, bit3 custom.
- n_buses  in  BUS_W  active bus count; sampled at start.
- sign_on  in  1  hub sign-on level.
- ph_done  in  1  generator done for the current bus and phase.
- ph_err  in  1  error flag; valid only with ph_done.
- req  out  1  1-cycle phase start request to the generator.
- phase  out  3  0 idle, 1 trim, 2 rx, 3 tx, 4 custom.
- bus_sel  out  BUS_W  bus under test.
- endwait_all  out  1  1-cycle pulse after the RX phase.
- busy  out  1  high from start acceptance until done.
- done  out  1  1-cycle completion pulse.
- pass_mask  out  N_BUSES  per-bus pass flags.
- fail_cnt  out  8  saturating count of failure events.
- timeout_flag  out  1  sticky; any timeout in the run.

## Operation
- States: IDLE, SIGNON, REQ, WAIT, NEXT, ENDW, GAP, FIN.
- Effective bus count: n_eff = n_buses, clamped to N_BUSES. If n_buses is 0 or greater than N_BUSES, n_eff = N_BUSES. n_eff is latched at start.
- IDLE + start:
  - Go to SIGNON and set busy.
  - pass_mask[i] = 1 for i < n_eff, 0 otherwise.
  - fail_cnt = 0; timeout_flag = 0.
- SIGNON:
  - Hold until sign_on = 1.
  - Then go to REQ with phase = lowest enabled phase and bus_sel = 0.
  - If mode_mask = 0, go to FIN.
- REQ: req = 1 for exactly one cycle, then WAIT.
- WAIT:
  - The timeout counter starts at 0 and increments each cycle.
  - ph_done = 1 → NEXT. If ph_err is also 1, record a fail.
  - Counter reaches TIMEOUT−1 without ph_done → record a fail, set timeout_flag, go to NEXT.
  - ph_done in the REQ cycle is ignored.
- Fail recording: clear pass_mask[bus_sel]; fail_cnt += 1, saturating at 255.
- NEXT:
  - If bus_sel < n_eff−1: bus_sel += 1, go to REQ.
  - Else if phase = rx: go to ENDW.
  - Else: next enabled phase, bus_sel = 0, go to REQ; or FIN if no phase remains.
- ENDW: endwait_all = 1 for one cycle, then GAP.
- GAP: wait exactly GAP_CYCLES cycles, then advance to the next enabled phase (or FIN) as in NEXT.
- FIN: done = 1, busy = 0, phase = 0, then IDLE. pass_mask, fail_cnt and timeout_flag hold until the next accepted start.
- abort (any non-IDLE state):
  - Next state is IDLE; req and endwait_all are forced to 0.
  - busy = 0; done is not pulsed.
  - Results freeze at their current values.
- Priority: abort > ph_done > timeout.

## Timing
- Reset values: all outputs 0, including pass_mask = 0; state IDLE.
- start at cycle t → busy at t+1 (SIGNON). If sign_on is already high: REQ at t+2, req high at t+2.
- Generator handshake:
  - req and ph_done are 1-cycle pulses.
  - phase and bus_sel are stable from REQ through NEXT.
  - The generator must not assert ph_done before the cycle after req.
- Per-bus cost: 3 + (ph_done latency) cycles.
  - ph_done at REQ+k → NEXT at REQ+k+1 → next REQ at REQ+k+2.
- Timeout bus: REQ+TIMEOUT → NEXT.
- After the RX phase: ENDW 1 cycle + GAP GAP_CYCLES cycles before the next REQ.
- Reset mid-run: immediate asynchronous return to reset values.

## Test plan
- Single bus, trim only:
  - Stimulus: n_buses=1, mode_mask=0001, sign_on high; ph_done 3 cycles after req.
  - Response: one req with phase=1, bus_sel=0; done 8 cycles after start; pass_mask=…0001; fail_cnt=0.
- RX then TX over 3 buses:
  - Stimulus: n_buses=3, mode_mask=0110.
  - Response: req sequence rx 0,1,2, then endwait_all pulse, then exactly 120 idle cycles, then tx 0,1,2; done; pass_mask=0x0007.
- Timeout and error:
  - Stimulus: TIMEOUT=16; bus 1 never answers; bus 2 answers with ph_err=1.
  - Response: pass_mask=0x0001; fail_cnt=2; timeout_flag=1; the bus 1 WAIT lasts 16 cycles.
- Clamping and gating:
  - Stimulus: n_buses=0, all phases enabled.
  - Response: 16 buses per phase; no req before sign_on rises.
  - Stimulus: a second start while busy.
  - Response: ignored; counters unchanged.
- Abort and reset:
  - Stimulus: abort during WAIT on bus 5.
  - Response: IDLE next cycle; no done; busy=0.
  - Stimulus: rst pulse mid-GAP.
  - Response: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mopshub_test_sequencer.sv
// mopshub_test_sequencer: walks every active CAN bus through the enabled test
// phases (trim, rx, tx, custom) and handshakes with the generator's per-bus
// test engines. Per-bus pass flags, a failure count and a timeout flag are
// collected along the way.
//
// state  | meaning
// IDLE   | waiting for start
// SIGNON | waiting for hub sign-on
// REQ    | one-cycle request to the generator for (phase, bus_sel)
// WAIT   | waiting for ph_done or the per-bus timeout
// NEXT   | select next bus, or next phase / end-wait / finish
// ENDW   | one-cycle end-wait pulse after the rx phase
// GAP    | fixed idle gap before the phase that follows rx
// FIN    | completion pulse, then back to IDLE
module mopshub_test_sequencer #(
    parameter int N_BUSES    = 16,
    parameter int BUS_W      = 5,
    parameter int TIMEOUT    = 4096,
    parameter int GAP_CYCLES = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         mode_mask,
    input  logic [BUS_W-1:0]   n_buses,
    input  logic               sign_on,
    input  logic               ph_done,
    input  logic               ph_err,
    output logic               req,
    output logic [2:0]         phase,
    output logic [BUS_W-1:0]   bus_sel,
    output logic               endwait_all,
    output logic               busy,
    output logic               done,
    output logic [N_BUSES-1:0] pass_mask,
    output logic [7:0]         fail_cnt,
    output logic               timeout_flag
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [2:0]       PH_RX = 3'd2;
    localparam logic [BUS_W-1:0] N_MAX = BUS_W'(N_BUSES);

    typedef enum logic [2:0] {
        S_IDLE, S_SIGNON, S_REQ, S_WAIT, S_NEXT, S_ENDW, S_GAP, S_FIN
    } state_t;

    state_t             state, state_nx;
    logic [2:0]         phase_q, phase_nx;
    logic [BUS_W-1:0]   bus_q, bus_nx;
    logic [BUS_W-1:0]   n_eff, n_eff_q;
    logic [3:0]         mask_q;
    logic [CNT_W-1:0]   cnt;
    logic [N_BUSES-1:0] pass_init, bus_hit;
    logic [2:0]         np;
    logic               fail_ev, to_ev;

    // Lowest enabled phase strictly above cur; 0 when none remains.
    function automatic logic [2:0] next_phase(input logic [2:0] cur, input logic [3:0] mask);
        logic [3:0] above;
        logic [3:0] cand;
        case (cur)
            3'd0:    above = 4'b1111;
            3'd1:    above = 4'b1110;
            3'd2:    above = 4'b1100;
            3'd3:    above = 4'b1000;
            default: above = 4'b0000;
        endcase
        cand = mask & above;
        if (cand[0])      return 3'd1;
        else if (cand[1]) return 3'd2;
        else if (cand[2]) return 3'd3;
        else if (cand[3]) return 3'd4;
        else              return 3'd0;
    endfunction

    // Zero or oversized bus counts mean "all buses".
    assign n_eff = (n_buses == '0 || n_buses > N_MAX) ? N_MAX : n_buses;

    for (genvar g = 0; g < N_BUSES; g++) begin : g_bus
        assign pass_init[g] = (BUS_W'(g) < n_eff);
        assign bus_hit[g]   = (bus_q == BUS_W'(g));
    end

    assign phase   = phase_q;
    assign bus_sel = bus_q;
    assign busy    = (state != S_IDLE) && (state != S_FIN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state, phase/bus selection and pulse outputs; abort overrides all.
    always_comb begin
        state_nx    = state;
        phase_nx    = phase_q;
        bus_nx      = bus_q;
        req         = 1'b0;
        endwait_all = 1'b0;
        done        = 1'b0;
        fail_ev     = 1'b0;
        to_ev       = 1'b0;
        np          = next_phase(phase_q, mask_q);
        case (state)
            S_IDLE: if (start) state_nx = S_SIGNON;
            S_SIGNON: begin
                if (sign_on) begin
                    if (mask_q == 4'd0) begin
                        state_nx = S_FIN;
                    end else begin
                        state_nx = S_REQ;
                        phase_nx = next_phase(3'd0, mask_q);
                        bus_nx   = '0;
                    end
                end
            end
            S_REQ: begin
                req      = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (ph_done) begin
                    state_nx = S_NEXT;
                    fail_ev  = ph_err;
                end else if (cnt == '0) begin
                    state_nx = S_NEXT;
                    fail_ev  = 1'b1;
                    to_ev    = 1'b1;
                end
            end
            S_NEXT: begin
                if (bus_q < n_eff_q - BUS_W'(1)) begin
                    bus_nx   = bus_q + BUS_W'(1);
                    state_nx = S_REQ;
                end else if (phase_q == PH_RX) begin
                    state_nx = S_ENDW;
                end else if (np == 3'd0) begin
                    state_nx = S_FIN;
                    phase_nx = 3'd0;
                    bus_nx   = '0;
                end else begin
                    state_nx = S_REQ;
                    phase_nx = np;
                    bus_nx   = '0;
                end
            end
            S_ENDW: begin
                endwait_all = 1'b1;
                state_nx    = S_GAP;
            end
            S_GAP: begin
                if (cnt == '0) begin
                    bus_nx = '0;
                    if (np == 3'd0) begin
                        state_nx = S_FIN;
                        phase_nx = 3'd0;
                    end else begin
                        state_nx = S_REQ;
                        phase_nx = np;
                    end
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nx    = S_IDLE;
            phase_nx    = 3'd0;
            bus_nx      = '0;
            req         = 1'b0;
            endwait_all = 1'b0;
            done        = 1'b0;
            fail_ev     = 1'b0;
            to_ev       = 1'b0;
        end
    end

    // Run configuration, shared timeout/gap down-counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= 3'd0;
            bus_q        <= '0;
            n_eff_q      <= '0;
            mask_q       <= 4'd0;
            cnt          <= '0;
            pass_mask    <= '0;
            fail_cnt     <= 8'd0;
            timeout_flag <= 1'b0;
        end else begin
            phase_q <= phase_nx;
            bus_q   <= bus_nx;
            if (state == S_IDLE && start) begin
                n_eff_q      <= n_eff;
                mask_q       <= mode_mask;
                pass_mask    <= pass_init;
                fail_cnt     <= 8'd0;
                timeout_flag <= 1'b0;
            end
            if (fail_ev) begin
                pass_mask <= pass_mask & ~bus_hit;
                if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
            end
            if (to_ev) timeout_flag <= 1'b1;
            case (state)
                S_REQ:         cnt <= CNT_W'(TIMEOUT - 1);
                S_ENDW:        cnt <= CNT_W'(GAP_CYCLES - 1);
                S_WAIT, S_GAP: if (cnt != '0) cnt <= cnt - CNT_W'(1);
                default:       ;
            endcase
        end
    end

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Bench for mopshub_test_sequencer: a generator model answers requests from
// per-phase/per-bus latency and error tables; a reference model computes the
// expected event timeline (req, endwait_all, done with results) from the
// handshake timing rules and queues it; a monitor pops and compares.
module tb_mopshub_test_sequencer;

    localparam int NB  = 16;
    localparam int BW  = 5;
    localparam int TO  = 16;
    localparam int GAP = 120;
    localparam int K_REQ  = 0;
    localparam int K_ENDW = 1;
    localparam int K_DONE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    mode_mask = 4'd0;
    logic [BW-1:0] n_buses = '0;
    logic          sign_on = 1'b0;
    logic          ph_done = 1'b0;
    logic          ph_err = 1'b0;
    logic          req;
    logic [2:0]    phase;
    logic [BW-1:0] bus_sel;
    logic          endwait_all;
    logic          busy;
    logic          done;
    logic [NB-1:0] pass_mask;
    logic [7:0]    fail_cnt;
    logic          timeout_flag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          kind;
        int          cyc;
        int          ph;
        int          bus;
        logic [NB-1:0] pm;
        int          fc;
        int          to;
    } ev_t;

    ev_t exp_q[$];

    int lat_tab [1:4][0:NB-1];
    bit err_tab [1:4][0:NB-1];
    int glitch_ph  = -1;
    int glitch_bus = -1;

    int            m_end, m_endw, m_abort_req, m_fc, m_to;
    logic [NB-1:0] m_pm;

    mopshub_test_sequencer #(
        .N_BUSES(NB), .BUS_W(BW), .TIMEOUT(TO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mode_mask(mode_mask), .n_buses(n_buses), .sign_on(sign_on),
        .ph_done(ph_done), .ph_err(ph_err), .req(req), .phase(phase),
        .bus_sel(bus_sel), .endwait_all(endwait_all), .busy(busy), .done(done),
        .pass_mask(pass_mask), .fail_cnt(fail_cnt), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Generator model: answers each req after lat_tab cycles (0 = never).
    int pend_cyc = -1;
    bit pend_err = 1'b0;
    int g_p, g_b;
    always @(negedge clk) begin
        ph_done = 1'b0;
        ph_err  = 1'b0;
        if (pend_cyc == cyc) begin
            ph_done  = 1'b1;
            ph_err   = pend_err;
            pend_cyc = -1;
        end
        if (!rst && req === 1'b1) begin
            g_p = int'(phase);
            g_b = int'(bus_sel);
            if (g_p >= 1 && g_p <= 4 && g_b < NB) begin
                if (lat_tab[g_p][g_b] > 0) begin
                    pend_cyc = cyc + lat_tab[g_p][g_b];
                    pend_err = err_tab[g_p][g_b];
                end
                if (g_p == glitch_ph && g_b == glitch_bus) begin
                    ph_done = 1'b1;
                    ph_err  = 1'b1;
                end
            end
        end
    end

    task automatic pop_cmp(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_event: DUT kind %0d at cycle %0d, queue empty", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == K_REQ) begin
                chk("req_phase", phase, e.ph);
                chk("req_bus", bus_sel, e.bus);
            end
            if (kind == K_DONE) begin
                chk("done_pass_mask", pass_mask, e.pm);
                chk("done_fail_cnt", fail_cnt, e.fc);
                chk("done_timeout_flag", timeout_flag, e.to);
            end
        end
    endtask

    // Monitor: every observable event is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (req === 1'b1)         pop_cmp(K_REQ);
            if (endwait_all === 1'b1) pop_cmp(K_ENDW);
            if (done === 1'b1)        pop_cmp(K_DONE);
        end
    end

    task automatic push_ev(input int kind, input int c, input int p, input int b,
                           input logic [NB-1:0] pm, input int fc, input int to);
        ev_t e;
        e.kind = kind; e.cyc = c; e.ph = p; e.bus = b; e.pm = pm; e.fc = fc; e.to = to;
        exp_q.push_back(e);
    endtask

    // Reference timeline: first req one cycle after sign-on is seen in SIGNON;
    // a bus answered after k cycles (TO if never) costs k+2 cycles; after rx an
    // end-wait cycle plus GAP idle cycles precede the next phase.
    task automatic model(input int n_raw, input logic [3:0] mask, input int t,
                         input int s, input int abort_idx);
        int n_eff, c, idx, k;
        bit stop;
        logic [NB-1:0] pm;
        int fc, to;
        n_eff = (n_raw == 0 || n_raw > NB) ? NB : n_raw;
        pm = '0;
        for (int b = 0; b < n_eff; b++) pm[b] = 1'b1;
        fc = 0; to = 0; idx = 0; stop = 1'b0;
        m_endw = -1; m_abort_req = -1;
        c = ((t + 1 > s) ? t + 1 : s) + 1;
        for (int p = 1; p <= 4; p++) begin
            if (!stop && mask[p-1]) begin
                for (int b = 0; b < n_eff; b++) begin
                    if (!stop) begin
                        push_ev(K_REQ, c, p, b, '0, 0, 0);
                        if (idx == abort_idx) begin
                            stop = 1'b1;
                            m_abort_req = c;
                        end else begin
                            k = (lat_tab[p][b] == 0) ? TO : lat_tab[p][b];
                            if (lat_tab[p][b] == 0 || err_tab[p][b]) begin
                                pm[b] = 1'b0;
                                if (fc < 255) fc++;
                            end
                            if (lat_tab[p][b] == 0) to = 1;
                            c = c + k + 2;
                            idx++;
                        end
                    end
                end
                if (p == 2 && !stop) begin
                    push_ev(K_ENDW, c, 0, 0, '0, 0, 0);
                    m_endw = c;
                    c = c + 1 + GAP;
                end
            end
        end
        m_pm = pm; m_fc = fc; m_to = to;
        if (!stop) begin
            push_ev(K_DONE, c, 0, 0, pm, fc, to);
            m_end = c;
        end else begin
            m_end = m_abort_req + 3;
        end
    endtask

    task automatic rand_tabs(input int to_pct, input int err_pct);
        for (int p = 1; p <= 4; p++) begin
            for (int b = 0; b < NB; b++) begin
                lat_tab[p][b] = (int'($urandom_range(0, 99)) < to_pct) ? 0 : int'($urandom_range(1, 12));
                err_tab[p][b] = (int'($urandom_range(0, 99)) < err_pct);
            end
        end
    endtask

    // One run: sign_dly <= 0 means sign_on already high; restart_dly > 0 pulses
    // a second start (with a different n_buses) while busy; abort_idx selects
    // the req index whose WAIT gets aborted; rst_gap_off >= 0 resets mid-GAP.
    task automatic run(input int n_raw, input logic [3:0] mask, input int sign_dly,
                       input int abort_idx, input int restart_dly, input int rst_gap_off);
        int t, s;
        bit was_reset;
        was_reset = 1'b0;
        @(negedge clk);
        sign_on   = (sign_dly <= 0);
        n_buses   = BW'(n_raw);
        mode_mask = mask;
        start     = 1'b1;
        t = cyc;
        s = (sign_dly <= 0) ? 0 : t + sign_dly;
        model(n_raw, mask, t, s, abort_idx);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (cyc < m_end + 2) begin
            @(negedge clk);
            if (sign_dly > 0 && cyc == s) sign_on = 1'b1;
            if (restart_dly > 0) begin
                if (cyc == t + restart_dly) begin
                    start   = 1'b1;
                    n_buses = BW'(3);
                end else begin
                    start = 1'b0;
                end
            end
            if (abort_idx >= 0 && cyc == m_abort_req + 2) abort = 1'b1;
            if (abort_idx >= 0 && cyc == m_abort_req + 3) begin
                abort = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_phase", phase, 0);
                chk("abort_req", req, 0);
                chk("abort_pass_mask", pass_mask, m_pm);
                chk("abort_fail_cnt", fail_cnt, m_fc);
                chk("abort_timeout_flag", timeout_flag, m_to);
            end
            if (rst_gap_off >= 0 && m_endw >= 0 && cyc == m_endw + 1 + rst_gap_off) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_req", req, 0);
                chk("rst_phase", phase, 0);
                chk("rst_bus_sel", bus_sel, 0);
                chk("rst_endwait_all", endwait_all, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_pass_mask", pass_mask, 0);
                chk("rst_fail_cnt", fail_cnt, 0);
                chk("rst_timeout_flag", timeout_flag, 0);
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                was_reset = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!was_reset) begin
            chk("queue_drained", exp_q.size(), 0);
            chk("idle_busy", busy, 0);
            chk("hold_pass_mask", pass_mask, m_pm);
            chk("hold_fail_cnt", fail_cnt, m_fc);
            chk("hold_timeout_flag", timeout_flag, m_to);
        end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_r, sd;
        logic [3:0] mk;
        rand_tabs(0, 0);
        @(negedge clk);
        chk("reset_req", req, 0);
        chk("reset_phase", phase, 0);
        chk("reset_bus_sel", bus_sel, 0);
        chk("reset_endwait_all", endwait_all, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pass_mask", pass_mask, 0);
        chk("reset_fail_cnt", fail_cnt, 0);
        chk("reset_timeout_flag", timeout_flag, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single bus, trim only: generator answers after 3 idle cycles.
        lat_tab[1][0] = 4;
        run(1, 4'b0001, 0, -1, 0, -1);
        chk("t1_pass_mask", pass_mask, 16'h0001);

        // rx then tx over 3 buses, all passing.
        rand_tabs(0, 0);
        run(3, 4'b0110, 0, -1, 0, -1);
        chk("t2_pass_mask", pass_mask, 16'h0007);

        // Bus 1 never answers (and glitches ph_done in its REQ cycle), bus 2 errors.
        rand_tabs(0, 0);
        lat_tab[1][0] = 3;
        lat_tab[1][1] = 0;
        lat_tab[1][2] = 5;
        err_tab[1][2] = 1'b1;
        glitch_ph  = 1;
        glitch_bus = 1;
        run(3, 4'b0001, 0, -1, 0, -1);
        chk("t3_pass_mask", pass_mask, 16'h0001);
        chk("t3_fail_cnt", fail_cnt, 2);
        chk("t3_timeout_flag", timeout_flag, 1);
        glitch_ph  = -1;
        glitch_bus = -1;

        // n_buses=0 clamps to all buses; late sign-on; second start ignored.
        rand_tabs(0, 20);
        run(0, 4'b1111, 7, -1, 40, -1);

        // Oversized bus count clamps too.
        rand_tabs(5, 10);
        run(20, 4'b1011, 0, -1, 0, -1);

        // Abort during WAIT on bus 5, coinciding with an erroring ph_done.
        rand_tabs(0, 30);
        lat_tab[1][5] = 2;
        err_tab[1][5] = 1'b1;
        run(8, 4'b0001, 0, 5, 0, -1);

        // Reset mid-GAP.
        rand_tabs(0, 30);
        run(2, 4'b0110, 0, -1, 0, 50);

        // Empty phase mask finishes straight after sign-on.
        run(4, 4'b0000, 3, -1, 0, -1);

        // Randomised runs.
        for (int r = 0; r < 6; r++) begin
            rand_tabs(8, 20);
            n_r = int'($urandom_range(0, 20));
            mk  = 4'($urandom_range(0, 15));
            sd  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 10));
            run(n_r, mk, sd, -1, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
